id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage integer pipeline, sitting between the IF/ID latch and EX. Each cycle it decodes the held instruction, drives the two regfile read ports (re1/raddr1, re2/raddr2), resolves RAW hazards against in-flight EX and MEM results, and registers operands and control into the ID/EX pipeline register. It raises a stall request back to IF on unresolved hazards and accepts downstream stall and flush.

## Interface
- No parameters. Widths are fixed: RegBus = 32, RegAddrBus = 5.
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  if_inst/if_pc hold a real instruction
- if_pc  in  32  PC of the instruction being decoded
- if_inst  in  32  instruction word
- re1 / re2  out  1  regfile read enables, combinational
- raddr1 / raddr2  out  5  regfile read addresses (rs / rt), combinational
- rdata1 / rdata2  in  32  regfile read data; the regfile already bypasses the WB write
- ex_we, ex_waddr[5], ex_wdata[32], ex_is_load  in  EX-stage pending write; ex_is_load means ex_wdata is not yet valid
- mem_we, mem_waddr[5], mem_wdata[32]  in  MEM-stage pending write
- ex_stall  in  1  downstream hold; ID/EX register must not advance
- flush  in  1  kill the instruction currently in ID
- id_stall_req  out  1  combinational; IF/ID must hold its contents
- id_ex_valid  out  1  registered; slot carries an instruction
- id_ex_pc  out  32  registered PC
- id_ex_aluop  out  4  registered: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 SLT
- id_ex_reg1 / id_ex_reg2  out  32  registered operands
- id_ex_wreg  out  1  registered destination write enable
- id_ex_wd  out  5  registered destination register
- id_ex_load  out  1  registered; instruction is LW

## Operation
- R-type (op 0) uses rs/rt and writes rd. Funct 0x24 AND, 0x25 OR, 0x26 XOR, 0x21 ADDU→ADD, 0x23 SUBU→SUB, 0x2A SLT.
- I-type writes rt and reads rs only (re2 = 0):
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: zero-extended immediate.
  - ADDIU 0x09: sign-extended immediate.
  - LUI 0x0F: OR with reg1 = 0 and reg2 = imm<<16.
  - LW 0x23: ADD with base + sign-extended immediate, id_ex_load = 1.
- Unknown encoding, or if_valid = 0: NOP (aluop 0, wreg 0, re1 = re2 = 0). The slot is valid only when if_valid = 1.
- Write to rd/rt = 0 forces wreg = 0.
- Source resolution per operand, only when its read enable is set and the address is nonzero. Priority: EX match, then MEM match, then rdata. A match requires *_we = 1 and an equal address. Address 0 always yields 0 and never stalls.
- Hazard stall:
  - FORWARD_EN defined: stall only when the EX match has ex_is_load = 1 (load-use).
  - FORWARD_EN undefined: stall on any EX or MEM match.
- Update priority at posedge:
  - rst: all id_ex_* cleared.
  - else flush: id_ex_valid = 0, other id_ex_* cleared.
  - else ex_stall: all id_ex_* held.
  - else hazard: bubble inserted (id_ex_valid = 0, wreg = 0, aluop = 0).
  - else: decoded values captured.
- id_stall_req = (hazard | ex_stall) & ~flush & ~rst.

## Timing
- Reset value of every registered output is 0. id_stall_req is 0 while rst is high.
- Latency is 1 cycle: an instruction present in cycle N appears on id_ex_* after the posedge ending cycle N.
- Load-use costs exactly 1 bubble with FORWARD_EN. The next cycle picks up the value from MEM.
- Without FORWARD_EN, stall persists while any match remains, up to 2 cycles plus the WB bypass.
- flush together with ex_stall: flush wins, the slot is invalidated and id_stall_req = 0.
- rst asserted mid-stall clears all outputs on the next edge, regardless of the other inputs.

## Configuration
- ID_FORWARD_EN defined: EX/MEM results are forwarded into operands, and only load-use stalls.
- ID_FORWARD_EN undefined: no forwarding paths; operands come only from rdata, and any pending EX/MEM write to a used source stalls.

## Test plan
- rst high for 2 cycles with random inputs → every id_ex_* = 0 and id_stall_req = 0.
- if_inst = 0x34018000 (ori $1,$0,0x8000), no pending writes → next cycle: aluop = 2, reg1 = 0, reg2 = 0x00008000, wreg = 1, wd = 1, valid = 1.
- if_inst = 0x00421821 (addu $3,$2,$2), ex_waddr = 2 / ex_wdata = 0x1234, mem_waddr = 2 / mem_wdata = 0x5555, both we = 1:
  - With FORWARD_EN: reg1 = reg2 = 0x1234 with no stall.
  - Without FORWARD_EN: id_stall_req = 1 and bubbles until no match remains.
- Load-use: ex_is_load = 1, ex_waddr = 4, if_inst = 0x00802825 (or $5,$4,$0) → id_stall_req = 1 and a bubble for one cycle. The next cycle, with mem_waddr = 4 / mem_wdata = 0xCAFE, gives reg1 = 0xCAFE, wd = 5.
- flush = 1 together with ex_stall = 1 while valid = 1 → next cycle valid = 0 and id_stall_req = 0.
- $0 source: if_inst = 0x00001021 (addu $2,$0,$0), ex_we = 1, ex_waddr = 0, ex_wdata = 0xFFFF → reg1 = reg2 = 0, no stall.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the five-stage integer pipeline.
// Decodes the IF/ID instruction, drives the regfile read ports, resolves RAW
// hazards against EX/MEM and registers operands/control into ID/EX.
// Build option: define ID_FORWARD_EN to enable EX/MEM operand forwarding
// (only load-use then stalls); undefined, any pending EX/MEM write to a used
// source stalls and operands come only from the regfile.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        re1,
  output logic        re2,
  output logic [4:0]  raddr1,
  output logic [4:0]  raddr2,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_is_load,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        id_stall_req,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [3:0]  id_ex_aluop,
  output logic [31:0] id_ex_reg1,
  output logic [31:0] id_ex_reg2,
  output logic        id_ex_wreg,
  output logic [4:0]  id_ex_wd,
  output logic        id_ex_load
);

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_ADD = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign opcode = if_inst[31:26];
  assign rs     = if_inst[25:21];
  assign rt     = if_inst[20:16];
  assign rd     = if_inst[15:11];
  assign imm    = if_inst[15:0];
  assign funct  = if_inst[5:0];

  // Read addresses always follow the rs/rt fields; the enables qualify them.
  assign raddr1 = rs;
  assign raddr2 = rt;

  logic [3:0]  r_aluop;
  logic [3:0]  dec_aluop;
  logic [4:0]  dec_wd;
  logic        dec_wreg;
  logic        dec_load;
  logic        dec_imm_sel;
  logic [31:0] dec_imm;

  // R-type function field to ALU operation; unknown functs decode as NOP.
  always_comb begin
    case (funct)
      6'h24:   r_aluop = ALU_AND;
      6'h25:   r_aluop = ALU_OR;
      6'h26:   r_aluop = ALU_XOR;
      6'h21:   r_aluop = ALU_ADD;
      6'h23:   r_aluop = ALU_SUB;
      6'h2A:   r_aluop = ALU_SLT;
      default: r_aluop = ALU_NOP;
    endcase
  end

  // Main decoder: ALU op, read enables, destination and immediate operand.
  always_comb begin
    dec_aluop   = ALU_NOP;
    dec_wd      = 5'd0;
    dec_load    = 1'b0;
    dec_imm_sel = 1'b0;
    dec_imm     = 32'd0;
    re1         = 1'b0;
    re2         = 1'b0;
    if (if_valid) begin
      case (opcode)
        OP_SPECIAL: if (r_aluop != ALU_NOP) begin
          dec_aluop = r_aluop;
          re1       = 1'b1;
          re2       = 1'b1;
          dec_wd    = rd;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          dec_aluop   = (opcode == OP_ANDI) ? ALU_AND :
                        (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
          re1         = 1'b1;
          dec_wd      = rt;
          dec_imm_sel = 1'b1;
          dec_imm     = {16'h0000, imm};
        end
        OP_ADDIU, OP_LW: begin
          dec_aluop   = ALU_ADD;
          re1         = 1'b1;
          dec_wd      = rt;
          dec_imm_sel = 1'b1;
          dec_imm     = {{16{imm[15]}}, imm};
          dec_load    = (opcode == OP_LW);
        end
        OP_LUI: begin
          // reg1 is a hard zero, so rs is not read and cannot cause a stall.
          dec_aluop   = ALU_OR;
          dec_wd      = rt;
          dec_imm_sel = 1'b1;
          dec_imm     = {imm, 16'h0000};
        end
        default: ;
      endcase
    end
    dec_wreg = (dec_aluop != ALU_NOP) && (dec_wd != 5'd0);
  end

  // Per-source-port hazard detection and operand selection.
  logic [1:0]  src_en;
  logic [4:0]  src_addr  [2];
  logic [31:0] src_rdata [2];
  logic [31:0] src_val   [2];
  logic [1:0]  src_used;
  logic [1:0]  ex_hit;
  logic [1:0]  mem_hit;
  logic [1:0]  src_haz;

  assign src_en       = {re2, re1};
  assign src_addr[0]  = raddr1;
  assign src_addr[1]  = raddr2;
  assign src_rdata[0] = rdata1;
  assign src_rdata[1] = rdata2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // $0 is never a real dependency: it reads as zero and never stalls.
      assign src_used[gi] = src_en[gi] & (src_addr[gi] != 5'd0);
      assign ex_hit[gi]   = src_used[gi] & ex_we  & (ex_waddr  == src_addr[gi]);
      assign mem_hit[gi]  = src_used[gi] & mem_we & (mem_waddr == src_addr[gi]);
`ifdef ID_FORWARD_EN
      // Youngest producer wins; a load in EX has no data yet, so it stalls.
      assign src_val[gi] = !src_used[gi] ? 32'd0 :
                           ex_hit[gi]    ? ex_wdata :
                           mem_hit[gi]   ? mem_wdata : src_rdata[gi];
      assign src_haz[gi] = ex_hit[gi] & ex_is_load;
`else
      assign src_val[gi] = src_used[gi] ? src_rdata[gi] : 32'd0;
      assign src_haz[gi] = ex_hit[gi] | mem_hit[gi];
`endif
    end
  endgenerate

`ifndef ID_FORWARD_EN
  // Forwarded data and the load flag only matter when forwarding is built in.
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata, mem_wdata, ex_is_load};
`endif

  logic        hazard;
  logic [31:0] op1;
  logic [31:0] op2;

  assign hazard       = |src_haz;
  assign op1          = src_val[0];
  assign op2          = dec_imm_sel ? dec_imm : src_val[1];
  assign id_stall_req = (hazard | ex_stall) & ~flush & ~rst;

  // ID/EX register: reset > flush > downstream hold > bubble > capture.
  always_ff @(posedge clk) begin
    if (rst || flush || (!ex_stall && hazard)) begin
      id_ex_valid <= 1'b0;
      id_ex_pc    <= 32'd0;
      id_ex_aluop <= ALU_NOP;
      id_ex_reg1  <= 32'd0;
      id_ex_reg2  <= 32'd0;
      id_ex_wreg  <= 1'b0;
      id_ex_wd    <= 5'd0;
      id_ex_load  <= 1'b0;
    end else if (!ex_stall) begin
      id_ex_valid <= if_valid;
      id_ex_pc    <= if_pc;
      id_ex_aluop <= dec_aluop;
      id_ex_reg1  <= op1;
      id_ex_reg2  <= op2;
      id_ex_wreg  <= dec_wreg;
      id_ex_wd    <= dec_wd;
      id_ex_load  <= dec_load;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized bench for id_stage against a
// behavioural decode/forwarding reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, ex_we, ex_is_load, mem_we, ex_stall, flush;
  logic [31:0] if_pc, if_inst, rdata1, rdata2, ex_wdata, mem_wdata;
  logic [4:0]  ex_waddr, mem_waddr;
  logic        re1, re2, id_stall_req, id_ex_valid, id_ex_wreg, id_ex_load;
  logic [4:0]  raddr1, raddr2, id_ex_wd;
  logic [31:0] id_ex_pc, id_ex_reg1, id_ex_reg2;
  logic [3:0]  id_ex_aluop;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .ex_stall(ex_stall), .flush(flush), .id_stall_req(id_stall_req),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_aluop(id_ex_aluop),
    .id_ex_reg1(id_ex_reg1), .id_ex_reg2(id_ex_reg2), .id_ex_wreg(id_ex_wreg),
    .id_ex_wd(id_ex_wd), .id_ex_load(id_ex_load)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: what the instruction means, independent of any datapath.
  typedef struct packed {
    logic [3:0]  alu;
    logic        u1;
    logic        u2;
    logic        useimm;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic        ld;
    logic        wr;
  } dec_t;

  function automatic dec_t ref_decode(input logic v, input logic [31:0] w);
    dec_t d;
    logic [5:0]  op;
    logic [15:0] i16;
    d = '0;
    op = w[31:26];
    i16 = w[15:0];
    if (v) begin
      if (op == 6'h00) begin
        case (w[5:0])
          6'h24: d.alu = 4'd1;
          6'h25: d.alu = 4'd2;
          6'h26: d.alu = 4'd3;
          6'h21: d.alu = 4'd4;
          6'h23: d.alu = 4'd5;
          6'h2A: d.alu = 4'd6;
          default: d.alu = 4'd0;
        endcase
        if (d.alu != 4'd0) begin
          d.u1 = 1'b1; d.u2 = 1'b1; d.dst = w[15:11];
        end
      end else begin
        d.useimm = 1'b1; d.u1 = 1'b1; d.dst = w[20:16];
        case (op)
          6'h0C: begin d.alu = 4'd1; d.imm = {16'h0, i16}; end
          6'h0D: begin d.alu = 4'd2; d.imm = {16'h0, i16}; end
          6'h0E: begin d.alu = 4'd3; d.imm = {16'h0, i16}; end
          6'h09: begin d.alu = 4'd4; d.imm = $signed(i16); end
          6'h0F: begin d.alu = 4'd2; d.imm = {i16, 16'h0}; d.u1 = 1'b0; end
          6'h23: begin d.alu = 4'd4; d.imm = $signed(i16); d.ld = 1'b1; end
          default: d = '0;
        endcase
      end
    end
    d.wr = (d.alu != 4'd0) && (d.dst != 5'd0);
    return d;
  endfunction

  // Value an operand should carry, and whether that source must wait.
  function automatic logic [31:0] ref_src(input logic u, input logic [4:0] a, input logic [31:0] rf);
    if (!u || a == 5'd0) return 32'd0;
`ifdef ID_FORWARD_EN
    if (ex_we && ex_waddr == a) return ex_wdata;
    if (mem_we && mem_waddr == a) return mem_wdata;
`endif
    return rf;
  endfunction

  function automatic logic ref_haz(input logic u, input logic [4:0] a);
    if (!u || a == 5'd0) return 1'b0;
`ifdef ID_FORWARD_EN
    return ex_we && ex_waddr == a && ex_is_load;
`else
    return (ex_we && ex_waddr == a) || (mem_we && mem_waddr == a);
`endif
  endfunction

  // Expected ID/EX contents; m_known is 0 where only valid/wreg/aluop are defined.
  logic        m_valid, m_wreg, m_load, m_known;
  logic [31:0] m_pc, m_reg1, m_reg2;
  logic [3:0]  m_aluop;
  logic [4:0]  m_wd;
  logic        last_stall;

  task automatic m_clear();
    m_valid = 0; m_pc = 0; m_aluop = 0; m_reg1 = 0; m_reg2 = 0;
    m_wreg = 0; m_wd = 0; m_load = 0; m_known = 1;
  endtask

  // One clock: check combinational outputs, clock, update model, check registers.
  task automatic step(input string tag);
    dec_t d;
    logic h;
    logic [31:0] v1, v2;
    #2;
    d  = ref_decode(if_valid, if_inst);
    h  = ref_haz(d.u1, if_inst[25:21]) | ref_haz(d.u2, if_inst[20:16]);
    v1 = ref_src(d.u1, if_inst[25:21], rdata1);
    v2 = d.useimm ? d.imm : ref_src(d.u2, if_inst[20:16], rdata2);
    last_stall = id_stall_req;
    check({tag, ".stall"}, id_stall_req, (h | ex_stall) & ~flush & ~rst);
    check({tag, ".re1"}, re1, d.u1);
    check({tag, ".re2"}, re2, d.u2);
    if (d.u1) check({tag, ".raddr1"}, raddr1, if_inst[25:21]);
    if (d.u2) check({tag, ".raddr2"}, raddr2, if_inst[20:16]);
    @(posedge clk);
    if (rst || flush) m_clear();
    else if (ex_stall) ;
    else if (h) begin
      m_valid = 0; m_wreg = 0; m_aluop = 0; m_known = 0;
    end else begin
      m_valid = if_valid; m_pc = if_pc; m_aluop = d.alu; m_reg1 = v1; m_reg2 = v2;
      m_wreg = d.wr; m_wd = d.dst; m_load = d.ld; m_known = 1;
    end
    #1;
    check({tag, ".valid"}, id_ex_valid, m_valid);
    check({tag, ".aluop"}, id_ex_aluop, m_aluop);
    check({tag, ".wreg"}, id_ex_wreg, m_wreg);
    if (m_known) begin
      check({tag, ".pc"}, id_ex_pc, m_pc);
      check({tag, ".reg1"}, id_ex_reg1, m_reg1);
      check({tag, ".reg2"}, id_ex_reg2, m_reg2);
      check({tag, ".load"}, id_ex_load, m_load);
      if (m_wreg) check({tag, ".wd"}, id_ex_wd, m_wd);
    end
  endtask

  task automatic quiet();
    rst = 0; flush = 0; ex_stall = 0; if_valid = 1; ex_we = 0; mem_we = 0;
    ex_is_load = 0; ex_waddr = 0; mem_waddr = 0; ex_wdata = 0; mem_wdata = 0;
    rdata1 = $urandom; rdata2 = $urandom; if_pc = $urandom;
  endtask

  logic [5:0] rfuncs [6] = '{6'h24, 6'h25, 6'h26, 6'h21, 6'h23, 6'h2A};
  logic [5:0] iops   [5] = '{6'h0C, 6'h0D, 6'h0E, 6'h09, 6'h23};

  function automatic logic [31:0] rand_inst();
    int k;
    logic [4:0] a, b, c;
    k = $urandom_range(0, 11);
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    if (k <= 5) return {6'h00, a, b, c, 5'd0, rfuncs[$urandom_range(0, 5)]};
    if (k <= 9) return {iops[$urandom_range(0, 4)], a, b, 16'($urandom)};
    if (k == 10) return {6'h0F, 5'd0, b, 16'($urandom)};
    return $urandom;
  endfunction

  initial begin
    quiet();
    if_inst = $urandom;
    m_clear();

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      rst = 1; if_valid = 1; if_inst = rand_inst(); ex_we = 1; ex_waddr = 5'($urandom);
      ex_stall = 1'($urandom); flush = 0;
      step("reset");
      check("reset.stall_const", last_stall, 0);
      check("reset.valid_const", id_ex_valid, 0);
      check("reset.reg1_const", id_ex_reg1, 0);
      check("reset.pc_const", id_ex_pc, 0);
    end

    // ori $1,$0,0x8000
    quiet(); if_inst = 32'h34018000;
    step("ori");
    check("ori.aluop_const", id_ex_aluop, 2);
    check("ori.reg1_const", id_ex_reg1, 0);
    check("ori.reg2_const", id_ex_reg2, 32'h00008000);
    check("ori.wd_const", id_ex_wd, 1);
    check("ori.valid_const", id_ex_valid, 1);

    // addu $3,$2,$2 with EX and MEM both producing $2.
    quiet(); if_inst = 32'h00421821;
    ex_we = 1; ex_waddr = 2; ex_wdata = 32'h1234;
    mem_we = 1; mem_waddr = 2; mem_wdata = 32'h5555;
    step("addu_fw");
`ifdef ID_FORWARD_EN
    check("addu.stall_const", last_stall, 0);
    check("addu.reg1_const", id_ex_reg1, 32'h1234);
    check("addu.reg2_const", id_ex_reg2, 32'h1234);
`else
    check("addu.stall_const", last_stall, 1);
    check("addu.bubble_const", id_ex_valid, 0);
    ex_we = 0;
    step("addu_mem_only");
    check("addu.stall2_const", last_stall, 1);
    mem_we = 0; rdata1 = 32'h1234; rdata2 = 32'h1234;
    step("addu_clear");
    check("addu.stall3_const", last_stall, 0);
    check("addu.reg1_const", id_ex_reg1, 32'h1234);
`endif

    // Load-use: or $5,$4,$0 behind a load to $4.
    quiet(); if_inst = 32'h00802825;
    ex_we = 1; ex_is_load = 1; ex_waddr = 4;
    step("lduse");
    check("lduse.stall_const", last_stall, 1);
    check("lduse.bubble_const", id_ex_valid, 0);
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_waddr = 4; mem_wdata = 32'hCAFE;
`ifndef ID_FORWARD_EN
    step("lduse_mem");
    check("lduse.stall2_const", last_stall, 1);
    mem_we = 0; rdata1 = 32'hCAFE;
`endif
    step("lduse_go");
    check("lduse.reg1_const", id_ex_reg1, 32'hCAFE);
    check("lduse.wd_const", id_ex_wd, 5);

    // flush wins over ex_stall.
    quiet(); if_inst = 32'h34018000;
    step("pre_flush");
    check("pre_flush.valid_const", id_ex_valid, 1);
    flush = 1; ex_stall = 1;
    step("flush_stall");
    check("flush.stall_const", last_stall, 0);
    check("flush.valid_const", id_ex_valid, 0);

    // $0 sources never forward or stall.
    quiet(); if_inst = 32'h00001021;
    ex_we = 1; ex_waddr = 0; ex_wdata = 32'hFFFF;
    step("zero_src");
    check("zero.stall_const", last_stall, 0);
    check("zero.reg1_const", id_ex_reg1, 0);
    check("zero.reg2_const", id_ex_reg2, 0);

    // Reset during a stall.
    quiet(); if_inst = 32'h00421821; ex_stall = 1;
    step("hold");
    rst = 1;
    step("rst_in_stall");
    check("rst_stall.valid_const", id_ex_valid, 0);
    check("rst_stall.aluop_const", id_ex_aluop, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      ex_stall   = ($urandom_range(0, 5) == 0);
      if_valid   = ($urandom_range(0, 99) < 85);
      if_inst    = rand_inst();
      if_pc      = $urandom;
      rdata1     = $urandom;
      rdata2     = $urandom;
      ex_we      = 1'($urandom);
      ex_waddr   = 5'($urandom_range(0, 7));
      ex_wdata   = $urandom;
      ex_is_load = ($urandom_range(0, 3) == 0);
      mem_we     = 1'($urandom);
      mem_waddr  = 5'($urandom_range(0, 7));
      mem_wdata  = $urandom;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
